// File: rtl/ppu_pkg.sv
// ppu_pkg: register indices, status bit positions and read-buffer FSM encoding
// shared by the PPU register interface and its $2007 fetch sub-module.
package ppu_pkg;

  // CPU-visible register indices (address bits [2:0])
  localparam logic [2:0] PPU_CTRL    = 3'd0;
  localparam logic [2:0] PPU_MASK    = 3'd1;
  localparam logic [2:0] PPU_STATUS  = 3'd2;
  localparam logic [2:0] PPU_OAMADDR = 3'd3;
  localparam logic [2:0] PPU_OAMDATA = 3'd4;
  localparam logic [2:0] PPU_SCROLL  = 3'd5;
  localparam logic [2:0] PPU_ADDR    = 3'd6;
  localparam logic [2:0] PPU_DATA    = 3'd7;

  // $2002 status bit positions
  localparam int STAT_VBL  = 7;
  localparam int STAT_SPR0 = 6;
  localparam int STAT_OVFL = 5;

  // Palette reads refill the buffer from the nametable underneath the palette
  localparam logic [14:0] PAL_SHADOW_OFS = 15'h1000;

  typedef enum logic [1:0] {
    RB_IDLE = 2'd0,
    RB_WAIT = 2'd1,
    RB_FILL = 2'd2
  } rdbuf_state_e;

  // Palette window: V[13:8] == $3F
  function automatic logic is_pal(input logic [14:0] v);
    return v[13:8] == 6'h3F;
  endfunction

endpackage

// File: rtl/ppu_rdbuf_fsm.sv
// ppu_rdbuf_fsm: $2007 read buffer and its VRAM fetch sequencer.
// A launch registers the address and issues a one-cycle read strobe the next
// cycle; the buffer captures VRAM data RD_LAT cycles after that strobe.
// A relaunch while waiting restarts the fetch; an abort drops it and keeps the buffer.
module ppu_rdbuf_fsm import ppu_pkg::*; #(
  parameter int RD_LAT = 1
) (
  input  logic        i_cpu_clk,
  input  logic        i_cpu_rstn,
  input  logic        start,
  input  logic        abort,
  input  logic [14:0] start_addr,
  input  logic [7:0]  vram_rdata,
  output logic        vram_re,
  output logic [14:0] fetch_addr,
  output logic [7:0]  rd_data,
  output logic        busy
);

  rdbuf_state_e state_reg, state_next;
  logic [1:0]   cnt_reg, cnt_next;
  logic [14:0]  addr_reg, addr_next;
  logic         re_reg, re_next;
  logic [7:0]   buf_reg, buf_next;

  // State, counter, address and buffer registers
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      state_reg <= RB_IDLE;
      cnt_reg   <= 2'd0;
      addr_reg  <= 15'd0;
      re_reg    <= 1'b0;
      buf_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      re_reg    <= re_next;
      buf_reg   <= buf_next;
    end
  end

  // Next-state: count out the latency, fill, then honour abort/relaunch
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    re_next    = 1'b0;
    buf_next   = buf_reg;
    case (state_reg)
      RB_WAIT: begin
        cnt_next = cnt_reg + 2'd1;
        if (cnt_reg == 2'(RD_LAT - 1)) state_next = RB_FILL;
      end
      RB_FILL: begin
        buf_next   = vram_rdata;
        state_next = RB_IDLE;
      end
      default: ;
    endcase
    if (abort) begin
      state_next = RB_IDLE;
      buf_next   = buf_reg;
    end
    if (start) begin
      state_next = RB_WAIT;
      cnt_next   = 2'd0;
      addr_next  = start_addr;
      re_next    = 1'b1;
    end
  end

  // A CPU write owns the VRAM port in its cycle, so it suppresses a pending strobe
  assign vram_re    = re_reg & ~abort;
  assign fetch_addr = addr_reg;
  // Data arriving in the fill cycle is forwarded so a read there sees the fresh value
  assign rd_data    = (state_reg == RB_FILL) ? vram_rdata : buf_reg;
  assign busy       = (state_reg != RB_IDLE);

endmodule

// File: rtl/ppu_regif.sv
// ppu_regif: CPU-facing PPU register file ($2000-$2007 mirrored to $3FFF).
// Holds CTRL/MASK/OAMADDR, Loopy T/V/fine-X/w, VBL/NMI, the open-bus latch and
// the $2007 read buffer (ppu_rdbuf_fsm).
// Build option: PPU_OPENBUS_DECAY_EN adds an open-bus decay timer of DECAY_CYC cycles.
module ppu_regif import ppu_pkg::*; #(
  parameter int VRAM_AW   = 14,
  parameter int RD_LAT    = 1,
  parameter int OAM_AW    = 8,
  parameter int DECAY_CYC = 1000000
) (
  input  logic               i_cpu_clk,
  input  logic               i_cpu_rstn,
  input  logic               i_bus_en,
  input  logic [15:0]        i_bus_addr,
  input  logic               i_bus_wn,
  input  logic [7:0]         i_bus_wdata,
  output logic [7:0]         o_ppu_rdata,
  output logic [OAM_AW-1:0]  o_oam_addr,
  output logic               o_oam_we,
  output logic [7:0]         o_oam_wdata,
  input  logic [7:0]         i_oam_rdata,
  output logic [VRAM_AW-1:0] o_vram_addr,
  output logic               o_vram_we,
  output logic               o_vram_re,
  output logic [7:0]         o_vram_wdata,
  input  logic [7:0]         i_vram_rdata,
  input  logic [7:0]         i_pal_rdata,
  output logic [7:0]         o_ppuctrl,
  output logic [7:0]         o_ppumask,
  output logic [14:0]        o_loopy_t,
  output logic [2:0]         o_fine_x,
  output logic               o_force_rld,
  output logic               o_rdbuf_busy,
  input  logic               i_spr_ovfl,
  input  logic               i_spr_0hit,
  input  logic               i_rde_run,
  input  logic               i_vblank,
  output logic               o_nmi_n
);

  logic [7:0]        ctrl_reg, mask_reg, ob_reg;
  logic [OAM_AW-1:0] oam_addr_reg;
  logic [14:0]       t_reg, v_reg;
  logic [2:0]        fine_x_reg;
  logic              w_reg, force_rld_reg, vbl_reg, vblank_d_reg;

  logic        acc, rd_acc, wr_acc, status_rd, data_acc;
  logic [2:0]  reg_idx;
  logic [14:0] v_step, fetch_addr;
  logic [7:0]  rdbuf_data;
  logic        unused_bits;

  assign acc       = i_bus_en & (i_bus_addr[15:13] == 3'b001);
  assign reg_idx   = i_bus_addr[2:0];
  assign rd_acc    = acc & i_bus_wn;
  assign wr_acc    = acc & ~i_bus_wn;
  assign status_rd = rd_acc & (reg_idx == PPU_STATUS);
  assign data_acc  = acc & (reg_idx == PPU_DATA);
  assign v_step    = ctrl_reg[2] ? 15'd32 : 15'd1;

  // CTRL/MASK/OAMADDR, Loopy T/V/fine-X, write toggle and the reload pulse
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      ctrl_reg      <= 8'd0;
      mask_reg      <= 8'd0;
      oam_addr_reg  <= '0;
      t_reg         <= 15'd0;
      v_reg         <= 15'd0;
      fine_x_reg    <= 3'd0;
      w_reg         <= 1'b0;
      force_rld_reg <= 1'b0;
    end else begin
      force_rld_reg <= 1'b0;
      if (data_acc) v_reg <= v_reg + v_step;
      if (status_rd) w_reg <= 1'b0;
      if (wr_acc) begin
        case (reg_idx)
          PPU_CTRL: begin
            ctrl_reg      <= i_bus_wdata;
            t_reg[11:10]  <= i_bus_wdata[1:0];
          end
          PPU_MASK:    mask_reg     <= i_bus_wdata;
          PPU_OAMADDR: oam_addr_reg <= OAM_AW'(i_bus_wdata);
          PPU_OAMDATA: if (!i_rde_run) oam_addr_reg <= oam_addr_reg + OAM_AW'(1);
          PPU_SCROLL: begin
            if (!w_reg) begin
              t_reg[4:0] <= i_bus_wdata[7:3];
              fine_x_reg <= i_bus_wdata[2:0];
            end else begin
              t_reg[9:5]   <= i_bus_wdata[7:3];
              t_reg[14:12] <= i_bus_wdata[2:0];
            end
            w_reg <= ~w_reg;
          end
          PPU_ADDR: begin
            if (!w_reg) begin
              t_reg[14:8] <= {1'b0, i_bus_wdata[5:0]};
            end else begin
              t_reg[7:0]    <= i_bus_wdata;
              v_reg         <= {t_reg[14:8], i_bus_wdata};
              force_rld_reg <= 1'b1;
            end
            w_reg <= ~w_reg;
          end
          default: ;
        endcase
      end
    end
  end

  // VBL flag: set on vblank rise unless a $2002 read races it, cleared on fall or read
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      vbl_reg      <= 1'b0;
      vblank_d_reg <= 1'b0;
    end else begin
      vblank_d_reg <= i_vblank;
      if ((~i_vblank & vblank_d_reg) | status_rd) vbl_reg <= 1'b0;
      else if (i_vblank & ~vblank_d_reg)         vbl_reg <= 1'b1;
    end
  end

`ifdef PPU_OPENBUS_DECAY_EN
  localparam int DW = $clog2(DECAY_CYC + 1);
  logic [DW-1:0] decay_cnt_reg;
  logic          refresh_all;

  assign refresh_all = rd_acc & ((reg_idx == PPU_OAMDATA) | (reg_idx == PPU_DATA));

  // Open-bus latch with decay: writes and refreshing reads restart the timer
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      ob_reg        <= 8'd0;
      decay_cnt_reg <= '0;
    end else if (wr_acc) begin
      ob_reg        <= i_bus_wdata;
      decay_cnt_reg <= '0;
    end else if (refresh_all) begin
      ob_reg        <= o_ppu_rdata;
      decay_cnt_reg <= '0;
    end else if (status_rd) begin
      ob_reg[7:5]   <= o_ppu_rdata[7:5];
      decay_cnt_reg <= '0;
    end else if (decay_cnt_reg != DW'(DECAY_CYC)) begin
      decay_cnt_reg <= decay_cnt_reg + DW'(1);
      if (decay_cnt_reg == DW'(DECAY_CYC - 1)) ob_reg <= 8'd0;
    end
  end
`else
  localparam int decay_unused = DECAY_CYC;

  // Open-bus latch: loaded by every decoded write, held indefinitely
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn)  ob_reg <= 8'd0;
    else if (wr_acc)  ob_reg <= i_bus_wdata;
  end
`endif

  ppu_rdbuf_fsm #(.RD_LAT(RD_LAT)) u_rdbuf (
    .i_cpu_clk  (i_cpu_clk),
    .i_cpu_rstn (i_cpu_rstn),
    .start      (rd_acc & (reg_idx == PPU_DATA)),
    .abort      (wr_acc & (reg_idx == PPU_DATA)),
    .start_addr (is_pal(v_reg) ? (v_reg - PAL_SHADOW_OFS) : v_reg),
    .vram_rdata (i_vram_rdata),
    .vram_re    (o_vram_re),
    .fetch_addr (fetch_addr),
    .rd_data    (rdbuf_data),
    .busy       (o_rdbuf_busy)
  );

  // Read data mux; write-only registers return the open-bus latch
  always_comb begin
    o_ppu_rdata = ob_reg;
    if (rd_acc) begin
      case (reg_idx)
        PPU_STATUS: begin
          o_ppu_rdata[STAT_VBL]  = vbl_reg;
          o_ppu_rdata[STAT_SPR0] = i_spr_0hit;
          o_ppu_rdata[STAT_OVFL] = i_spr_ovfl;
        end
        PPU_OAMDATA: o_ppu_rdata = i_oam_rdata;
        PPU_DATA:    o_ppu_rdata = is_pal(v_reg) ? i_pal_rdata : rdbuf_data;
        default:     o_ppu_rdata = ob_reg;
      endcase
    end
  end

  assign o_oam_addr   = oam_addr_reg;
  assign o_oam_we     = wr_acc & (reg_idx == PPU_OAMDATA) & ~i_rde_run;
  assign o_oam_wdata  = i_bus_wdata;
  assign o_vram_we    = wr_acc & (reg_idx == PPU_DATA);
  assign o_vram_wdata = i_bus_wdata;
  assign o_vram_addr  = o_vram_re ? fetch_addr[VRAM_AW-1:0] : v_reg[VRAM_AW-1:0];
  assign o_ppuctrl    = {ctrl_reg[7:2], t_reg[11:10]};
  assign o_ppumask    = mask_reg;
  assign o_loopy_t    = t_reg;
  assign o_fine_x     = fine_x_reg;
  assign o_force_rld  = force_rld_reg;
  assign o_nmi_n      = ~(vbl_reg & ctrl_reg[7]);

  assign unused_bits  = ^{i_bus_addr[12:3], fetch_addr, ctrl_reg[1:0]};

endmodule

// File: tb/tb_ppu_regif.sv
// tb_ppu_regif: directed scoreboard bench for ppu_regif (RD_LAT=2).
// Stimulus pushes expectations into a queue; a negedge monitor pops and compares.
module tb_ppu_regif;

  localparam int RD_LAT = 2;

  typedef enum int {K_RD, K_NMI, K_VADDR, K_VWE, K_VWD, K_OAMWE, K_OAMWD,
                    K_OAMADDR, K_CTRL, K_MASK, K_T, K_FX, K_BUSY, K_RLD} kind_e;
  typedef struct {
    kind_e       kind;
    string       name;
    logic [15:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        bus_en = 1'b0, bus_wn = 1'b1;
  logic [15:0] bus_addr = 16'h0;
  logic [7:0]  bus_wdata = 8'h0;
  logic [7:0]  ppu_rdata, oam_wdata, vram_wdata, vram_rdata, ppuctrl, ppumask;
  logic [7:0]  oam_rdata = 8'h00, pal_rdata = 8'hE1;
  logic [7:0]  oam_addr;
  logic [13:0] vram_addr;
  logic        oam_we, vram_we, vram_re, force_rld, rdbuf_busy, nmi_n;
  logic [14:0] loopy_t;
  logic [2:0]  fine_x;
  logic        spr_ovfl = 1'b0, spr_0hit = 1'b0, rde_run = 1'b0, vblank = 1'b0;

  exp_t sb[$];
  int   cmp_cnt = 0;
  int   fail_cnt = 0;
  int   rld_cnt = 0;

  logic [7:0] lat_d [RD_LAT];
  logic       lat_v [RD_LAT];

  always #5 clk = ~clk;

  ppu_regif #(.VRAM_AW(14), .RD_LAT(RD_LAT), .OAM_AW(8), .DECAY_CYC(1000)) dut (
    .i_cpu_clk(clk), .i_cpu_rstn(rstn),
    .i_bus_en(bus_en), .i_bus_addr(bus_addr), .i_bus_wn(bus_wn), .i_bus_wdata(bus_wdata),
    .o_ppu_rdata(ppu_rdata),
    .o_oam_addr(oam_addr), .o_oam_we(oam_we), .o_oam_wdata(oam_wdata), .i_oam_rdata(oam_rdata),
    .o_vram_addr(vram_addr), .o_vram_we(vram_we), .o_vram_re(vram_re),
    .o_vram_wdata(vram_wdata), .i_vram_rdata(vram_rdata), .i_pal_rdata(pal_rdata),
    .o_ppuctrl(ppuctrl), .o_ppumask(ppumask), .o_loopy_t(loopy_t), .o_fine_x(fine_x),
    .o_force_rld(force_rld), .o_rdbuf_busy(rdbuf_busy),
    .i_spr_ovfl(spr_ovfl), .i_spr_0hit(spr_0hit), .i_rde_run(rde_run), .i_vblank(vblank),
    .o_nmi_n(nmi_n)
  );

  // VRAM contents used by the tests
  function automatic logic [7:0] vram_model(input logic [13:0] a);
    case (a)
      14'h2108: return 8'hAA;
      14'h2109: return 8'hBB;
      14'h2F05: return 8'h77;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // VRAM with RD_LAT cycles of latency after the read strobe; garbage otherwise
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) begin
        lat_v[i] <= 1'b0;
        lat_d[i] <= 8'h00;
      end
    end else begin
      lat_v[0] <= vram_re;
      lat_d[0] <= vram_model(vram_addr);
      for (int i = 1; i < RD_LAT; i++) begin
        lat_v[i] <= lat_v[i-1];
        lat_d[i] <= lat_d[i-1];
      end
    end
  end
  assign vram_rdata = lat_v[RD_LAT-1] ? lat_d[RD_LAT-1] : 8'hEE;

  always @(posedge clk) if (rstn && force_rld) rld_cnt <= rld_cnt + 1;

  function automatic logic [15:0] sig_val(input kind_e k);
    case (k)
      K_RD:      return (bus_en && bus_wn) ? {8'h00, ppu_rdata} : 16'hFFFF;
      K_NMI:     return {15'd0, nmi_n};
      K_VADDR:   return {2'd0, vram_addr};
      K_VWE:     return {15'd0, vram_we};
      K_VWD:     return {8'h00, vram_wdata};
      K_OAMWE:   return {15'd0, oam_we};
      K_OAMWD:   return {8'h00, oam_wdata};
      K_OAMADDR: return {8'h00, oam_addr};
      K_CTRL:    return {8'h00, ppuctrl};
      K_MASK:    return {8'h00, ppumask};
      K_T:       return {1'b0, loopy_t};
      K_FX:      return {13'd0, fine_x};
      K_BUSY:    return {15'd0, rdbuf_busy};
      default:   return 16'(rld_cnt);
    endcase
  endfunction

  // Monitor: every expectation queued for this cycle is checked at the falling edge
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e = sb.pop_front();
      act = sig_val(e.kind);
      cmp_cnt++;
      if (act !== e.exp) begin
        fail_cnt++;
        $display("FAIL %-12s actual=%h required=%h", e.name, act, e.exp);
      end else begin
        $display("ok   %-12s value=%h", e.name, act);
      end
    end
  end

  task automatic chk(input kind_e k, input string nm, input logic [15:0] v);
    sb.push_back('{k, nm, v});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus_en = 1'b0;
      bus_wn = 1'b1;
    end
  endtask

  task automatic wr(input logic [2:0] r, input logic [7:0] d);
    @(posedge clk); #1;
    bus_en = 1'b1; bus_wn = 1'b0; bus_addr = 16'h2008 | {13'd0, r}; bus_wdata = d;
  endtask

  task automatic rd(input logic [2:0] r, input logic [7:0] v, input string nm);
    @(posedge clk); #1;
    bus_en = 1'b1; bus_wn = 1'b1; bus_addr = 16'h3FF0 | {13'd0, r};
    chk(K_RD, nm, {8'h00, v});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset state
    chk(K_NMI, "rst_nmi", 16'h1);     chk(K_CTRL, "rst_ctrl", 16'h0);
    chk(K_T, "rst_t", 16'h0);         chk(K_FX, "rst_fx", 16'h0);
    chk(K_OAMADDR, "rst_oamaddr", 0); chk(K_BUSY, "rst_busy", 16'h0);
    chk(K_VADDR, "rst_vaddr", 16'h0); chk(K_MASK, "rst_mask", 16'h0);
    rd(3'd2, 8'h00, "rst_status");
    idle(1);

    // 1: $2006 pair, buffered $2007 reads
    wr(3'd6, 8'h21); wr(3'd6, 8'h08);
    idle(1); chk(K_T, "t1_t", 16'h2108); chk(K_VADDR, "t1_v", 16'h2108);
    rd(3'd7, 8'h00, "t1_rd0");
    idle(1); chk(K_VADDR, "t1_fetch", 16'h2108); chk(K_BUSY, "t1_busy", 16'h1);
    idle(3); chk(K_BUSY, "t1_idle", 16'h0); chk(K_VADDR, "t1_v2", 16'h2109);
    rd(3'd7, 8'hAA, "t1_rd1");
    idle(4); chk(K_VADDR, "t1_v3", 16'h210A); chk(K_RLD, "t1_rld", 16'd1);
    rd(3'd7, 8'hBB, "t1_rd2");
    idle(4);

    // 2: increment by 32 wraps the 14-bit VRAM address
    wr(3'd0, 8'h04); idle(1); chk(K_CTRL, "t2_ctrl", 16'h0004);
    wr(3'd6, 8'h3F); wr(3'd6, 8'hF0);
    wr(3'd7, 8'h5A); chk(K_VWE, "t2_we", 16'h1); chk(K_VADDR, "t2_waddr", 16'h3FF0);
    chk(K_VWD, "t2_wdata", 16'h005A);
    idle(1); chk(K_VWE, "t2_we_off", 16'h0); chk(K_VADDR, "t2_wrap", 16'h0010);
    chk(K_RLD, "t2_rld", 16'd2);

    // 3: palette read bypass, shadow refill, restart and write abort
    wr(3'd0, 8'h00); wr(3'd6, 8'h3F); wr(3'd6, 8'h05);
    pal_rdata = 8'h1C;
    rd(3'd7, 8'h1C, "t3_pal");
    idle(1); chk(K_VADDR, "t3_shadow", 16'h2F05);
    idle(3); chk(K_VADDR, "t3_v", 16'h3F06);
    wr(3'd6, 8'h20); wr(3'd6, 8'h00);
    rd(3'd7, 8'h77, "t3_buf77");
    idle(4);
    rd(3'd7, 8'h5A, "t3_rs_a");
    rd(3'd7, 8'h5A, "t3_rs_b");
    idle(4);
    rd(3'd7, 8'h58, "t3_rs_win");
    wr(3'd7, 8'h11); chk(K_VADDR, "t3_ab_addr", 16'h2004); chk(K_VWE, "t3_ab_we", 16'h1);
    idle(4);
    rd(3'd7, 8'h58, "t3_ab_keep");
    idle(4);

    // 4: VBL/NMI
    wr(3'd0, 8'h80);
    idle(1); chk(K_CTRL, "t4_ctrl", 16'h0080);
    vblank = 1'b1; chk(K_NMI, "t4_nmi_edge", 16'h1);
    idle(1); chk(K_NMI, "t4_nmi_on", 16'h0);
    rd(3'd2, 8'h80, "t4_status");
    idle(1); chk(K_NMI, "t4_nmi_clr", 16'h1);
    vblank = 1'b0;
    idle(1); wr(3'd0, 8'h00);
    idle(1); vblank = 1'b1;
    idle(1); chk(K_NMI, "t4_nmi_dis", 16'h1);
    wr(3'd0, 8'h80); chk(K_NMI, "t4_nmi_wr", 16'h1);
    idle(1); chk(K_NMI, "t4_nmi_late", 16'h0);
    vblank = 1'b0; chk(K_NMI, "t4_nmi_fall", 16'h0);
    idle(1); chk(K_NMI, "t4_nmi_off", 16'h1);

    // 5: $2002 read racing the vblank rise
    spr_0hit = 1'b1;
    rd(3'd2, 8'h40, "t5_race"); vblank = 1'b1;
    idle(1); chk(K_NMI, "t5_nmi_a", 16'h1);
    idle(1); chk(K_NMI, "t5_nmi_b", 16'h1);
    rd(3'd2, 8'h40, "t5_suppr");
    idle(1); chk(K_NMI, "t5_nmi_c", 16'h1);
    vblank = 1'b0; spr_0hit = 1'b0;
    idle(1);

    // 6: OAM writes during rendering, w reset by $2002, open bus
    wr(3'd3, 8'h10);
    rde_run = 1'b1;
    wr(3'd4, 8'hAB); chk(K_OAMWE, "t6_we_drop", 16'h0);
    idle(1); chk(K_OAMADDR, "t6_addr_hold", 16'h0010);
    rde_run = 1'b0;
    wr(3'd4, 8'hCD); chk(K_OAMWE, "t6_we", 16'h1); chk(K_OAMWD, "t6_wd", 16'h00CD);
    idle(1); chk(K_OAMADDR, "t6_addr_inc", 16'h0011);
    oam_rdata = 8'h3C;
    rd(3'd4, 8'h3C, "t6_oam_rd");
    idle(1); chk(K_OAMADDR, "t6_addr_rd", 16'h0011);
    wr(3'd5, 8'h7D); wr(3'd5, 8'h2B);
    idle(1); chk(K_T, "t6_t_scroll", 16'h30AF); chk(K_FX, "t6_fx", 16'h5);
    wr(3'd5, 8'h7D);
    rd(3'd2, 8'h1D, "t6_status");
    wr(3'd5, 8'h13);
    idle(1); chk(K_T, "t6_t_w0", 16'h30A2); chk(K_FX, "t6_fx_w0", 16'h3);
    rd(3'd0, 8'h13, "t6_ob_ctrl");
    rd(3'd6, 8'h13, "t6_ob_addr");
    wr(3'd1, 8'h1E);
    idle(1); chk(K_MASK, "t6_mask", 16'h001E);
    spr_ovfl = 1'b1;
    rd(3'd2, 8'h3E, "t6_ovfl");
    idle(3);

    if (sb.size() != 0) begin
        fail_cnt++;
        $display("FAIL sb_drain      actual=%0d required=0", sb.size());
    end else begin
        $display("ok   sb_drain      value=0");
    end
    if (cmp_cnt < 12) begin
        fail_cnt++;
        $display("FAIL cmp_count     actual=%0d required>=12", cmp_cnt);
    end else begin
        $display("ok   cmp_count     value=%0d", cmp_cnt);
    end
    if (fail_cnt != 0) begin
        $display("FAIL fail_count    actual=%0d required=0", fail_cnt);
    end else begin
        $display("ok   fail_count    value=0");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout       actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
